// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, PC+4, Execute redirect and the IF/ID pipeline register.
// Optional macro FETCH_MISALIGN_CHECK_EN aligns redirect targets and flags the fetched instruction.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCF,
  input  logic [31:0]     InstrF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            MisalignD
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] w_pc_plus4_f;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc_plus4_d;
  logic            r_valid_d;

  assign w_pc_plus4_f = r_pc_f + PC_STEP;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign_f;
  logic r_misalign_d;
  logic w_tgt_misaligned;

  assign w_redirect_pc    = {PCTargetE[XLEN-1:2], 2'b00};
  assign w_tgt_misaligned = |PCTargetE[1:0];

  // F-stage flag describes the instruction the PC currently addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign_f <= 1'b0;
    end else if (PCSrcE) begin
      r_misalign_f <= w_tgt_misaligned;
    end else if (StallF) begin
      r_misalign_f <= r_misalign_f;
    end else begin
      r_misalign_f <= 1'b0;
    end
  end

  // Flag travels through IF/ID alongside its instruction
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      r_misalign_d <= 1'b0;
    end else if (StallD) begin
      r_misalign_d <= r_misalign_d;
    end else begin
      r_misalign_d <= r_misalign_f;
    end
  end

  assign MisalignD = r_misalign_d;
`else
  assign w_redirect_pc = PCTargetE;
  assign MisalignD     = 1'b0;
`endif

  // Next PC: a redirect outranks StallF so a taken branch is never lost
  always_comb begin
    w_pc_next = w_pc_plus4_f;
    if (PCSrcE) begin
      w_pc_next = w_redirect_pc;
    end else if (StallF) begin
      w_pc_next = r_pc_f;
    end else begin
      w_pc_next = w_pc_plus4_f;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f <= RESET_PC;
    end else begin
      r_pc_f <= w_pc_next;
    end
  end

  // IF/ID register: flush beats stall, both load a bubble or hold every field
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (StallD) begin
      r_instr_d    <= r_instr_d;
      r_pc_d       <= r_pc_d;
      r_pc_plus4_d <= r_pc_plus4_d;
      r_valid_d    <= r_valid_d;
    end else begin
      r_instr_d    <= InstrF;
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= w_pc_plus4_f;
      r_valid_d    <= 1'b1;
    end
  end

  assign PCF      = r_pc_f;
  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc_plus4_d;
  assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected post-edge state,
// a monitor pops and compares it one step after every rising edge.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        MisalignD;

  typedef struct packed {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: what the fetch stage should hold
  logic [31:0] m_pc    = 32'h0;
  logic        m_mis_f = 1'b0;
  exp_t        m_d;

  fetch_stage #(.XLEN(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PCF(PCF), .InstrF(InstrF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignD(MisalignD)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  assign InstrF = mem(PCF);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one cycle of inputs, advance the model across the coming edge, queue the result
  task automatic cyc(input logic r, input logic sf, input logic sd, input logic fd,
                     input logic ps, input logic [31:0] tgt);
    exp_t e;
    reset = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    if (r || fd) begin
      m_d = '{pcf: 32'h0, instr: NOP, pcd: 32'h0, pcp4: 32'h0, valid: 1'b0, mis: 1'b0};
    end else if (!sd) begin
      m_d = '{pcf: 32'h0, instr: mem(m_pc), pcd: m_pc, pcp4: m_pc + 32'd4, valid: 1'b1, mis: m_mis_f};
    end
    if (r) begin
      m_pc = RST_PC; m_mis_f = 1'b0;
    end else if (ps) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      m_pc = tgt & 32'hFFFF_FFFC; m_mis_f = (tgt % 32'd4) != 32'd0;
`else
      m_pc = tgt; m_mis_f = 1'b0;
`endif
    end else if (!sf) begin
      m_pc = m_pc + 32'd4; m_mis_f = 1'b0;
    end
    e = m_d;
    e.pcf = m_pc;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are valid every cycle, compare after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (PCF !== e.pcf || InstrD !== e.instr || PCD !== e.pcd || PCPlus4D !== e.pcp4 ||
          ValidD !== e.valid || MisalignD !== e.mis) begin
        bad++;
        $display("FAIL cycle_state t=%0t got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h V=%b M=%b exp PCF=%h InstrD=%h PCD=%h PCPlus4D=%h V=%b M=%b",
                 $time, PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignD,
                 e.pcf, e.instr, e.pcd, e.pcp4, e.valid, e.mis);
      end
    end
  end

  initial begin
    m_d = '{pcf: 32'h0, instr: NOP, pcd: 32'h0, pcp4: 32'h0, valid: 1'b0, mis: 1'b0};
    // reset held three cycles then free-run
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // redirect to 0x10, then stall both stages for two cycles
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010);
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // redirect beats StallF, with flush
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // flush and stall together
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // PC wrap at the top of the address space
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // misaligned redirect target
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // reset in the middle of activity overrides everything
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 2),  ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 10), $urandom);
    end
    @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage and IF/ID pipeline register for the pipelined RISC-V core. It owns the program counter, PC+4 generation, branch/jump redirect from Execute, and the Fetch→Decode register with stall, flush and bubble insertion. It replaces the single-cycle PC register/PC-mux path, adding configurable width and reset vector, hazard control, and a valid bit.

## Interface
- XLEN, 32, address/PC width (≥ 16)
- RESET_PC, 0, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID register
- FlushD  in  1  load bubble into IF/ID
- PCSrcE  in  1  redirect request from Execute (taken branch / JAL / JALR)
- PCTargetE  in  XLEN  redirect target
- PCF  out  XLEN  current PC, drives instruction-memory address
- InstrF  in  32  instruction word read at PCF (combinational memory)
- InstrD  out  32  Decode-stage instruction
- PCD  out  XLEN  PC of InstrD
- PCPlus4D  out  XLEN  PCD + 4
- ValidD  out  1  InstrD is a real instruction (0 = bubble)
- MisalignD  out  1  InstrD was fetched at a misaligned redirect target

## Operation
- PC register next value, priority high→low: reset → RESET_PC; PCSrcE → PCTargetE; StallF → hold; else PCF + 4.
- Redirect beats StallF: a taken branch is never dropped while Decode is stalled.
- PCPlus4F = PCF + 4, modulo 2^XLEN (wraps from all-ones-minus-3 to 0, no flag).
- IF/ID register, priority high→low: reset → bubble; FlushD → bubble; StallD → hold all fields; else load {InstrF, PCF, PCPlus4F, ValidF=1, MisalignF}.
- Bubble = InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0, MisalignD = 0.
- FlushD and StallD together: flush wins.
- This block does not self-flush on PCSrcE; the hazard unit asserts FlushD (and FlushE) in the redirect cycle.
- No state machine beyond the PC register, the F-stage misalign flag and the IF/ID register.

## Timing
- Reset values: PCF = RESET_PC, InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0, MisalignD = 0. Reset asserted mid-stream overrides every other input in that cycle.
- First real instruction: reset deasserted at edge N → InstrD = mem[RESET_PC], ValidD = 1 after edge N+1.
- PCSrcE sampled at edge N → PCF = PCTargetE after edge N; target instruction reaches D after edge N+1.
- Stall latency zero: StallF/StallD high at edge N → that edge's update suppressed.
- PCF is a pure register output; InstrF → InstrD is the only memory-to-register path.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: on redirect with PCTargetE[1:0] ≠ 0, PC loads {PCTargetE[XLEN-1:2], 2'b00} and F-stage flag MisalignF is set; MisalignF clears on the next PC advance (increment or redirect) and is held while StallF. MisalignD carries it through IF/ID with the instruction.
- Undefined: PC loads PCTargetE verbatim, MisalignF/MisalignD tied 0, no extra flops.

## Test plan
- Reset held 3 cycles with RESET_PC = 32'h0000_1000, then released → PCF = 1000, 1004, 1008; ValidD = 0 first cycle, then InstrD = mem[1000] with PCD = 1000, PCPlus4D = 1004.
- StallF = StallD = 1 for 2 cycles at PCF = 0x10 → PCF, InstrD, PCD frozen; on release PCF = 0x14 next edge.
- PCSrcE = 1, PCTargetE = 0x200, FlushD = 1 in same cycle with StallF = 1 → PCF = 0x200 next edge, ValidD = 0, InstrD = NOP_INSTR; next edge PCD = 0x200.
- FlushD = StallD = 1 simultaneously → bubble loaded, ValidD = 0.
- PCF = 32'hFFFF_FFFC, no stall → PCF wraps to 0, PCPlus4D of that instruction = 0.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → PCF = 0x100, MisalignD = 1 for that instruction, 0 for the one at 0x104; without macro PCF = 0x102, MisalignD = 0.
